// File: rtl/spectrum_bar_smoother_pkg.sv
// Shared types and constants for the spectrum bar smoother.
package visualizer_pkg;

    localparam int BIN_W       = 10;
    localparam int NUM_BINS    = 16;
    localparam int DECAY_SHIFT = 3;
    localparam int HOLD_FRAMES = 30;
    localparam int PEAK_FALL   = 2;
    localparam int HOLD_W      = $clog2(HOLD_FRAMES + 1);

    typedef logic [BIN_W-1:0] bin_t;
    typedef bin_t [NUM_BINS-1:0] bin_arr_t;

    typedef enum logic [1:0] {IDLE, LOAD, PROC, DONE} smoother_state_e;

endpackage

// File: rtl/spectrum_bar_smoother_if.sv
// Bin input, frame tick, status and random-access read port of the bar smoother.
interface spectrum_bar_smoother_if;

    logic                   new_t;
    visualizer_pkg::bin_arr_t t;
    logic                   frame_tick;
    logic [3:0]             rd_idx;
    visualizer_pkg::bin_t   rd_bar;
    visualizer_pkg::bin_t   rd_peak;
    logic                   busy;
    logic                   upd_done;
    logic                   ovf;

    modport master (
        output new_t, t, frame_tick, rd_idx,
        input  rd_bar, rd_peak, busy, upd_done, ovf
    );

    modport slave (
        input  new_t, t, frame_tick, rd_idx,
        output rd_bar, rd_peak, busy, upd_done, ovf
    );

endinterface

// File: rtl/spectrum_bar_smoother_bar_step.sv
// Single-bin attack/decay: instant rise to the sample, proportional fall (minimum 1).
module bar_step
    import visualizer_pkg::*;
(
    input  bin_t s,
    input  bin_t b,
    output bin_t b_next
);

    bin_t diff;
    bin_t step;

    always_comb begin
        diff = b - s;
        step = diff >> DECAY_SHIFT;
        if (step == '0) step = bin_t'(1);
        b_next = (s >= b) ? s : (b - step);
    end

endmodule

// File: rtl/spectrum_bar_smoother.sv
// Per-bar display smoothing with a shared single-bin sequencer.
// Build option: define PEAK_HOLD_EN to add peak-hold markers driven by frame_tick.
//
// state | meaning
// IDLE  | waiting; frame ticks applied here; starts on request or pending request
// LOAD  | snapshot t0..t15 into samples, idx <- 0
// PROC  | update bar idx through bar_step, idx++ until 15
// DONE  | upd_done pulse, back to IDLE
module spectrum_bar_smoother
    import visualizer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    spectrum_bar_smoother_if.slave bus
);

    smoother_state_e state;
    logic [2:0]      sync;
    logic            upd_req;
    logic            pend;
    logic [3:0]      idx;
    bin_arr_t        samples;
    bin_arr_t        bars;
    bin_t            step_b;
    logic            busy;
    logic            upd_done;
    logic            ovf;

    bar_step u_bar_step (
        .s      (samples[idx]),
        .b      (bars[idx]),
        .b_next (step_b)
    );

    // new_t is a level from another domain: two sync flops plus one for the edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            upd_req <= 1'b0;
        end else begin
            sync    <= {sync[1:0], bus.new_t};
            upd_req <= sync[1] & ~sync[2];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pend     <= 1'b0;
            idx      <= '0;
            samples  <= '0;
            bars     <= '0;
            busy     <= 1'b0;
            upd_done <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            upd_done <= 1'b0;
            ovf      <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_req || pend) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        pend  <= 1'b0;
                        if (upd_req && pend) ovf <= 1'b1;
                    end
                end
                LOAD: begin
                    samples <= bus.t;
                    idx     <= '0;
                    state   <= PROC;
                end
                PROC: begin
                    bars[idx] <= step_b;
                    idx       <= idx + 4'd1;
                    if (idx == 4'd15) begin
                        state    <= DONE;
                        upd_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // one-deep request queue; extra requests are coalesced and flagged
            if (state != IDLE && upd_req) begin
                if (pend) ovf  <= 1'b1;
                else      pend <= 1'b1;
            end
        end
    end

    assign bus.rd_bar   = bars[bus.rd_idx];
    assign bus.busy     = busy;
    assign bus.upd_done = upd_done;
    assign bus.ovf      = ovf;

`ifdef PEAK_HOLD_EN
    bin_arr_t          peaks;
    logic [HOLD_W-1:0] holds [NUM_BINS];
    logic              tick_pend;
    logic              tick_apply;

    // ticks are deferred while the sequencer owns the bars so they never race an update
    assign tick_apply = (state == IDLE) && (bus.frame_tick || tick_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            peaks     <= '0;
            tick_pend <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) holds[i] <= '0;
        end else begin
            if (state == IDLE)       tick_pend <= 1'b0;
            else if (bus.frame_tick) tick_pend <= 1'b1;
            for (int i = 0; i < NUM_BINS; i++) begin
                if (state == PROC && idx == 4'(i)) begin
                    if (step_b >= peaks[i]) begin
                        peaks[i] <= step_b;
                        holds[i] <= HOLD_W'(HOLD_FRAMES);
                    end
                end else if (tick_apply) begin
                    if (holds[i] != '0)
                        holds[i] <= holds[i] - HOLD_W'(1);
                    else if ({1'b0, peaks[i]} > ({1'b0, bars[i]} + (BIN_W+1)'(PEAK_FALL)))
                        peaks[i] <= peaks[i] - BIN_W'(PEAK_FALL);
                    else
                        peaks[i] <= bars[i];
                end
            end
        end
    end

    assign bus.rd_peak = peaks[bus.rd_idx];
`else
    logic unused_tick;
    assign unused_tick = bus.frame_tick;
    assign bus.rd_peak = bus.rd_bar;
`endif

endmodule

// File: doc/spectrum_bar_smoother.md
# spectrum_bar_smoother

Consumes the 16 spectrum bins (t0..t15, 10 bits each) and the new_t update strobe from the microphone translation stage. It produces per-bar display heights with instant attack and proportional decay, plus peak-hold markers that fall once per video frame. The VGA bar renderer reads the results through a random-access read port. The block sits between mic translation and the display renderer.

## Interface
- BIN_W, 10: bin/bar width in bits
- DECAY_SHIFT, 3: bar decay step = (bar − sample) >> DECAY_SHIFT
- HOLD_FRAMES, 30: frame ticks a new peak is held before falling
- PEAK_FALL, 2: peak decrement per frame tick after hold expires
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- new_t  in  1  update strobe; level, may be asynchronous to Clk
- t0..t15  in  10 each  bin magnitudes; stable ≥ 4 Clk cycles after new_t rises
- frame_tick  in  1  one-cycle pulse per video frame, Clk domain
- rd_idx  in  4  bar index for read port
- rd_bar  out  10  smoothed height of bar rd_idx (combinational from registers)
- rd_peak  out  10  peak marker of bar rd_idx (combinational)
- busy  out  1  high while an update is in progress (LOAD..DONE)
- upd_done  out  1  one-cycle pulse when all 16 bars are updated
- ovf  out  1  one-cycle pulse when a new_t edge is coalesced/dropped

## Operation
- new_t passes a 2-flop synchronizer; a rising-edge detector yields upd_req (one cycle).
- FSM states:
  - IDLE: moves to LOAD on upd_req or pend.
  - LOAD: snapshots t0..t15 into the sample array; idx ← 0.
  - PROC: updates bin idx, idx++; leaves after idx = 15.
  - DONE: pulses upd_done, then returns to IDLE.
- Bin update, sample s, bar b:
  - s ≥ b: b ← s.
  - Otherwise step = (b − s) >> DECAY_SHIFT, forced to 1 if 0; b ← b − step.
  - All arithmetic is unsigned BIN_W; no underflow is possible.
- Peak on bin update: if new b ≥ peak, then peak ← b and hold ← HOLD_FRAMES.
- Frame tick, applied to all 16 bins in parallel, only in IDLE:
  - hold > 0: hold−−.
  - Otherwise, peak > b + PEAK_FALL: peak ← peak − PEAK_FALL.
  - Otherwise: peak ← b.
- A frame_tick arriving outside IDLE sets tick_pend. It is applied on the first IDLE cycle and tick_pend then clears.
- upd_req outside IDLE sets pend (one deep).
  - upd_req while pend is already set: ovf pulses and the request is coalesced.
  - upd_req in IDLE with pend set: pend is consumed and ovf pulses.
- IDLE with a tick and a request in the same cycle: the tick is applied and the FSM enters LOAD in that same cycle. There is no register conflict.
- Reset (any state, including mid-PROC) clears:
  - bars, peaks, hold counters, samples
  - pend, tick_pend, sync flops
  - FSM → IDLE
  - busy, upd_done, ovf all 0 after the reset cycle

## Timing
- upd_req asserts 3 Clk edges after new_t rises (2 sync + edge detect). Call this cycle N.
- LOAD in N+1. PROC in N+2..N+17; bar i is visible at rd_bar in cycle N+3+i.
- DONE/upd_done in N+18. IDLE in N+19.
- A pending request re-enters LOAD at N+20.
- busy is registered and high N+1..N+18.
- Read port has zero latency; rd_idx changes are reflected in the same cycle.

## Configuration
- PEAK_HOLD_EN:
  - Defined: peak registers, hold counters, frame_tick logic and tick_pend are implemented as described.
  - Undefined: all of the above are removed; rd_peak = rd_bar, frame_tick is ignored, and the bar update path is unchanged.

## Structure
- Package visualizer_pkg holds:
  - NUM_BINS = 16
  - bin_t (logic [BIN_W-1:0])
  - bin_arr_t (bin_t [NUM_BINS])
  - smoother_state_e {IDLE, LOAD, PROC, DONE}
- Sub-module bar_step: combinational single-bin attack/decay. Inputs s, b; output new b. It is instanced once and shared by the PROC sequencer.

## Test plan
- Reset, then read all 16 indices → rd_bar = rd_peak = 0; busy, upd_done, ovf = 0.
- t3 = 800, others 0, new_t rise → upd_done exactly 18 cycles after upd_req; rd_bar[3] = 800, rd_peak[3] = 800, all others 0.
- Then three updates with t3 = 0 → bar3 = 700, 613, 537. Preload bar = 5, sample 0 → 4 (minimum step 1).
- Peak hold after bar3 settles to 613 with peak 800: 30 frame_ticks → peak3 still 800; 31st → 798. Continue ticking → eventually peak3 = bar3 (snap).
- Second new_t edge mid-PROC → second update starts at N+20, two upd_done pulses, no ovf. Third edge in the same window → ovf pulses once.
- Reset asserted at PROC idx = 7 → next cycle busy = 0, all bars/peaks 0; next new_t runs a full clean update.
